vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder_pkg.sv | 29 ++
 rtl/vga_sync_decoder_edge.sv | 36 +++
 rtl/vga_sync_decoder.sv | 195 +++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_decoder_pkg.sv
// Shared timing constants, coordinate widths and lock-state encoding
// for the VGA sync decoder.
package vga_sync_decoder_pkg;

  // 640x480 @ 60 Hz timing, pixel clocks / lines
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNCW  = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNCW  = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNCW + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNCW + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;

  localparam int XBITS = 10;
  localparam int YBITS = 10;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_HLOCK    = 2'd1,
    ST_LOCKED   = 2'd2
  } sync_state_e;

endpackage

// File: rtl/vga_sync_decoder_edge.sv
// Stage-1 register for one sync line: normalises polarity to
// asserted-high and flags the sample where it first becomes asserted.
module vga_sync_edge #(
  parameter bit SYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_in,
  output logic level,
  output logic lead_edge
);

  logic level_q, level_d;
  logic prev_q, prev_d;

  // Normalised level of the incoming pin, plus the previous stage-1 sample
  always_comb begin
    level_d = (sync_in == SYNC_POL);
    prev_d  = level_q;
  end

  // History starts deasserted so a pin already asserted at release is an edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      prev_q  <= prev_d;
    end
  end

  assign level     = level_q;
  assign lead_edge = level_q & ~prev_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from a raw VGA stream. Stage 1 registers the
// pins, stage 2 registers every output, so outputs trail the pins by 2 clk.
module vga_sync_decoder
  import vga_sync_decoder_pkg::*;
#(
  parameter int HACTIVE  = H_ACTIVE,
  parameter int HFP      = H_FP,
  parameter int HSYNCW   = H_SYNCW,
  parameter int HBP      = H_BP,
  parameter int VACTIVE  = V_ACTIVE,
  parameter int VFP      = V_FP,
  parameter int VSYNCW   = V_SYNCW,
  parameter int VBP      = V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [3:0]        red,
  input  logic [3:0]        green,
  input  logic [3:0]        blue,
  output logic [XBITS-1:0]  x,
  output logic [YBITS-1:0]  y,
  output logic              activevideo,
  output logic              pixel_valid,
  output logic [11:0]       pixel_data,
  output logic              locked,
  output logic              frame_start,
  output logic              sync_error,
  output sync_state_e       dbg_state
);

  localparam int HTOTAL = HACTIVE + HFP + HSYNCW + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSYNCW + VBP;

  localparam logic [XBITS-1:0] HLAST_X  = XBITS'(HTOTAL - 1);
  localparam logic [XBITS-1:0] HSTART_X = XBITS'(HACTIVE + HFP);
  localparam logic [XBITS-1:0] HACT_X   = XBITS'(HACTIVE);
  localparam logic [YBITS-1:0] VLAST_Y  = YBITS'(VTOTAL - 1);
  localparam logic [YBITS-1:0] VSTART_Y = YBITS'(VACTIVE + VFP);
  localparam logic [YBITS-1:0] VACT_Y   = YBITS'(VACTIVE);

  // Stage 1
  logic        hs_level, hs_edge, vs_level_unused, vs_edge;
  logic [11:0] rgb_q, rgb_d;
  logic        s1_vld_q, s1_vld_d;

  vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_hs_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .sync_in   (hsync),
    .level     (hs_level),
    .lead_edge (hs_edge)
  );

  vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_vs_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .sync_in   (vsync),
    .level     (vs_level_unused),
    .lead_edge (vs_edge)
  );

  // Stage-1 colour capture; s1_vld marks that stage 1 holds a real sample
  always_comb begin
    rgb_d    = {red, green, blue};
    s1_vld_d = 1'b1;
  end

  // Stage-1 colour and valid registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q    <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      s1_vld_q <= s1_vld_d;
    end
  end

  // Stage 2: x_q/y_q hold the coordinates of the previous sample, so the
  // free-run value is that plus one; the very first sample is (0,0).
  sync_state_e            state_q, state_d;
  logic                   run_q, run_d;
  logic [XBITS-1:0]       x_q, x_d, h_free, h_cur;
  logic [YBITS-1:0]       y_q, y_d, v_free, v_cur;
  logic                   active_q, active_d, pvalid_q, pvalid_d;
  logic [11:0]            pdata_q, pdata_d;
  logic                   locked_q, locked_d, fstart_q, fstart_d;
  logic                   serr_q, serr_d;
  logic                   h_err, v_err;
  sync_state_e            state_nx;

  // Free-running counters with sync-edge corrections
  always_comb begin
    h_free = '0;
    v_free = '0;
    if (run_q) begin
      if (x_q == HLAST_X) begin
        h_free = '0;
        v_free = (y_q == VLAST_Y) ? '0 : y_q + 1'b1;
      end else begin
        h_free = x_q + 1'b1;
        v_free = y_q;
      end
    end
    h_cur = hs_edge ? HSTART_X : h_free;
    v_cur = vs_edge ? VSTART_Y : v_free;
  end

  // Lock FSM: errors are judged against the free-run count, and both error
  // sources merge into one pulse
  always_comb begin
    h_err = (state_q != ST_UNLOCKED) &&
            ((hs_edge && (h_free != HSTART_X)) ||
             (!hs_level && (h_free == HSTART_X)));
    v_err = (state_q == ST_LOCKED) && vs_edge && (v_free != VSTART_Y);
    state_nx = state_q;
    if (h_err || v_err) begin
      state_nx = ST_UNLOCKED;
    end else begin
      case (state_q)
        ST_UNLOCKED: if (hs_edge) state_nx = ST_HLOCK;
        ST_HLOCK:    if (vs_edge && (h_free == '0)) state_nx = ST_LOCKED;
        ST_LOCKED:   state_nx = ST_LOCKED;
        default:     state_nx = ST_UNLOCKED;
      endcase
    end
  end

  // Next output values; stage 2 only advances once stage 1 holds a sample
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    x_d      = x_q;
    y_d      = y_q;
    active_d = active_q;
    pvalid_d = pvalid_q;
    pdata_d  = pdata_q;
    locked_d = locked_q;
    fstart_d = fstart_q;
    serr_d   = serr_q;
    if (s1_vld_q) begin
      state_d  = state_nx;
      run_d    = 1'b1;
      x_d      = h_cur;
      y_d      = v_cur;
      active_d = (h_cur < HACT_X) && (v_cur < VACT_Y);
      locked_d = (state_nx == ST_LOCKED);
      pvalid_d = active_d && locked_d;
      pdata_d  = pvalid_d ? rgb_q : 12'h000;
      fstart_d = locked_d && (h_cur == '0) && (v_cur == '0);
      serr_d   = h_err || v_err;
    end
  end

  // FSM state and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_UNLOCKED;
      run_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b0;
      pvalid_q <= 1'b0;
      pdata_q  <= '0;
      locked_q <= 1'b0;
      fstart_q <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      pvalid_q <= pvalid_d;
      pdata_q  <= pdata_d;
      locked_q <= locked_d;
      fstart_q <= fstart_d;
      serr_q   <= serr_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign activevideo = active_q;
  assign pixel_valid = pvalid_q;
  assign pixel_data  = pdata_q;
  assign locked      = locked_q;
  assign frame_start = fstart_q;
  assign sync_error  = serr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced timing so several frames fit.
module tb_vga_sync_decoder;
  import vga_sync_decoder_pkg::*;

  localparam int HA = 48, HF = 4, HW = 6, HB = 6;
  localparam int VA = 20, VF = 3, VW = 2, VB = 5;
  localparam int HT = HA + HF + HW + HB;
  localparam int VT = VA + VF + VW + VB;
  localparam int HS = HA + HF;
  localparam int VS = VA + VF;
  localparam bit TB_POL = 1'b0;
  localparam int OW = 37;

  localparam int T_NONE = 0, T_PIX = 1, T_PORCH = 2, T_HD = 3, T_SKIP = 4, T_VF = 5;
  localparam int M_FREE = 0, M_HALIGN = 1, M_FULL = 2;

  typedef struct {
    int         tag;
    logic [3:0] b;
  } meta_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        hsync = 1'b1, vsync = 1'b1;
  logic [3:0]  red = '0, green = '0, blue = '0;
  logic [9:0]  x, y;
  logic        activevideo, pixel_valid, locked, frame_start, sync_error;
  logic [11:0] pixel_data;
  sync_state_e dbg_state;

  vga_sync_decoder #(
    .HACTIVE(HA), .HFP(HF), .HSYNCW(HW), .HBP(HB),
    .VACTIVE(VA), .VFP(VF), .VSYNCW(VW), .VBP(VB), .SYNC_POL(TB_POL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .x(x), .y(y), .activevideo(activevideo), .pixel_valid(pixel_valid),
    .pixel_data(pixel_data), .locked(locked), .frame_start(frame_start),
    .sync_error(sync_error), .dbg_state(dbg_state)
  );

  // scoreboard
  logic [OW-1:0] exp_q[$];
  meta_t         meta_q[$];
  int checks = 0, failures = 0;
  int se_cnt = 0, fs_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // stream generator state and injected faults
  int gx = 0, gy = 0;
  int delay_line = -1, skip_line = -1, fake_v = -1;
  bit pix_chk_en = 1'b0;
  bit do_release = 1'b0;

  // reference model: coordinates kept as a linear pixel index
  int m_h = 0, m_v = 0, m_mode = M_FREE;
  bit m_run = 1'b0, m_prev_hs = 1'b0, m_prev_vs = 1'b0;

  task automatic model_reset();
    m_h = 0; m_v = 0; m_mode = M_FREE;
    m_run = 1'b0; m_prev_hs = 1'b0; m_prev_vs = 1'b0;
  endtask

  task automatic model_step(input bit hs, input bit vs, input logic [11:0] rgb,
                            output logic [OW-1:0] want);
    int fh, fv, h, v, lin;
    bit he, ve, err, av, lk, pv;
    he = hs && !m_prev_hs;
    ve = vs && !m_prev_vs;
    fh = 0; fv = 0;
    if (m_run) begin
      lin = (m_v * HT + m_h + 1) % (HT * VT);
      fh = lin % HT;
      fv = lin / HT;
    end
    h = he ? HS : fh;
    v = ve ? VS : fv;
    err = 1'b0;
    if (m_mode != M_FREE && he && fh != HS) err = 1'b1;
    if (m_mode != M_FREE && !hs && fh == HS) err = 1'b1;
    if (m_mode == M_FULL && ve && fv != VS) err = 1'b1;
    if (err) m_mode = M_FREE;
    else if (m_mode == M_FREE && he) m_mode = M_HALIGN;
    else if (m_mode == M_HALIGN && ve && fh == 0) m_mode = M_FULL;
    av = (h < HA) && (v < VA);
    lk = (m_mode == M_FULL);
    pv = av && lk;
    want = {10'(h), 10'(v), av, pv, (pv ? rgb : 12'h000), lk,
            (lk && h == 0 && v == 0), err};
    m_h = h; m_v = v; m_run = 1'b1; m_prev_hs = hs; m_prev_vs = vs;
  endtask

  // drive the next stream sample and record what it should produce
  task automatic drive_sample();
    bit hs, vs;
    logic [11:0] rgb;
    logic [OW-1:0] want;
    meta_t m;
    hs = (gx >= HS) && (gx < HS + HW);
    if (gy == delay_line) hs = (gx >= HS + 3) && (gx < HS + 3 + HW);
    if (gy == skip_line) hs = 1'b0;
    vs = ((gy >= VS) && (gy < VS + VW)) || ((fake_v >= 0) && (gy >= fake_v) && (gy < fake_v + VW));
    rgb = {4'((gx >> 2) & 15), 4'((gy >> 2) & 15), 4'($urandom_range(0, 15))};
    hsync = hs ? TB_POL : ~TB_POL;
    vsync = vs ? TB_POL : ~TB_POL;
    {red, green, blue} = rgb;
    m.tag = T_NONE;
    m.b = rgb[3:0];
    if (pix_chk_en && gx == 37 && gy == 12) m.tag = T_PIX;
    if (pix_chk_en && gx == HA + 2 && gy == 12) m.tag = T_PORCH;
    if (gy == delay_line && gx == HS + 3) m.tag = T_HD;
    if (gy == skip_line && gx == HS) m.tag = T_SKIP;
    if (gy == fake_v && gx == 0) m.tag = T_VF;
    if (reset_n) begin
      model_step(hs, vs, rgb, want);
      exp_q.push_back(want);
      meta_q.push_back(m);
    end
    gx++;
    if (gx == HT) begin
      gx = 0;
      gy = (gy + 1) % VT;
    end
  endtask

  // one clock: check the output due now, then drive the next sample
  task automatic step();
    logic [OW-1:0] got, want;
    meta_t m;
    @(negedge clk);
    if (do_release) begin
      reset_n = 1'b1;
      do_release = 1'b0;
    end
    got = {x, y, activevideo, pixel_valid, pixel_data, locked, frame_start, sync_error};
    if (!reset_n || exp_q.size() < 2) begin
      check_val("idle", got, '0);
    end else begin
      want = exp_q.pop_front();
      m = meta_q.pop_front();
      check_val("out", got, want);
      if (sync_error) se_cnt++;
      if (frame_start) fs_cnt++;
      case (m.tag)
        T_PIX: begin
          check_val("pix_x", x, 37);
          check_val("pix_y", y, 12);
          check_val("pix_valid", pixel_valid, 1);
          check_val("pix_data", pixel_data, {8'h93, m.b});
        end
        T_PORCH: begin
          check_val("porch_valid", pixel_valid, 0);
          check_val("porch_data", pixel_data, 0);
        end
        T_HD: begin
          check_val("hdelay_edge_x", x, HS);
          check_val("hdelay_edge_locked", locked, 0);
        end
        T_SKIP: begin
          check_val("skip_err", sync_error, 1);
          check_val("skip_x", x, HS);
          check_val("skip_locked", locked, 0);
        end
        T_VF: begin
          check_val("vfake_err", sync_error, 1);
          check_val("vfake_y", y, VS);
          check_val("vfake_locked", locked, 0);
        end
        default: ;
      endcase
    end
    drive_sample();
  endtask

  task automatic run_until(input int tx, input int ty);
    int n;
    n = 0;
    while (!(gx == tx && gy == ty) && n <= HT * VT) begin
      step();
      n++;
    end
    if (!(gx == tx && gy == ty)) check_val("run_until_timeout", 1, 0);
  endtask

  task automatic run_frames(input int nf);
    repeat (nf * HT * VT) step();
  endtask

  int se0, fs0;

  initial begin
    // power-up reset from a random stream position
    gx = $urandom_range(0, HT - 1);
    gy = $urandom_range(0, VT - 1);
    model_reset();
    repeat (4) step();
    check_val("reset_locked", locked, 0);
    do_release = 1'b1;
    run_frames(2);
    check_val("lock_initial", locked, 1);
    check_val("lock_state", dbg_state, ST_LOCKED);

    // one clean frame: exactly one frame_start, no errors, pixel spot checks
    pix_chk_en = 1'b1;
    run_until(0, 1);
    se0 = se_cnt; fs0 = fs_cnt;
    run_frames(1);
    pix_chk_en = 1'b0;
    check_val("fs_per_frame", fs_cnt - fs0, 1);
    check_val("clean_no_err", se_cnt - se0, 0);

    // hsync pulse delayed by 3 clocks on one line
    run_until(0, 5);
    delay_line = 5; se0 = se_cnt;
    run_until(0, 7);
    delay_line = -1;
    check_val("hdelay_err_seen", (se_cnt > se0), 1);
    check_val("hdelay_unlock", locked, 0);
    run_frames(2);
    check_val("hdelay_relock", locked, 1);

    // one hsync pulse missing
    run_until(0, 8);
    skip_line = 8; se0 = se_cnt;
    run_until(0, 10);
    skip_line = -1;
    check_val("skip_err_once", se_cnt - se0, 1);
    check_val("skip_unlock", locked, 0);
    run_frames(2);
    check_val("skip_relock", locked, 1);

    // spurious vsync at line 10: no frame_start until relock
    run_until(0, 10);
    fake_v = 10; se0 = se_cnt; fs0 = fs_cnt;
    run_until(0, 12);
    fake_v = -1;
    check_val("vfake_err_once", se_cnt - se0, 1);
    run_until(5, VS);
    check_val("vfake_no_fs", fs_cnt - fs0, 0);
    check_val("vfake_relock", locked, 1);

    // asynchronous reset mid-frame while locked
    run_until(HA / 2, VA / 2);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("reset_async_outs",
              {x, y, activevideo, pixel_valid, pixel_data, locked, frame_start, sync_error}, 0);
    exp_q.delete();
    meta_q.delete();
    model_reset();
    repeat (3) step();
    do_release = 1'b1;
    run_until(0, VS - 2);
    check_val("reset_nolock", locked, 0);
    run_frames(2);
    check_val("reset_relock", locked, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
